// File: rtl/fabric_mem_store_port.sv
// Store-side memory responder: queues store addresses and data independently,
// pairs the queue heads, writes the word into a local array and returns a done token.

module fabric_mem_store_port_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_ready,
    output logic             o_nonempty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_slots [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_rptr_nxt;
    logic             w_push;

    // Ready comes from the registered count only, so a full queue never accepts
    // in the same cycle that its head pops.
    assign o_ready    = (r_count < CW'(DEPTH));
    assign o_nonempty = (r_count != '0);
    assign o_head     = r_slots[r_rptr];
    assign w_push     = i_valid && o_ready;

    // Next pointer values, wrapping at DEPTH
    always_comb begin
        w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
        w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (i_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_slots[r_wptr] <= i_data;
        end
    end
endmodule

module fabric_mem_store_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 0,
    parameter int MEM_DEPTH   = 64,
    parameter int QUEUE_DEPTH = 4,
    localparam int TW1 = (TAG_WIDTH > 0) ? TAG_WIDTH : 1,
    localparam int AW  = $clog2(MEM_DEPTH),
    localparam int QW  = DATA_WIDTH + TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    input  logic [QW-1:0]         addr_data,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [QW-1:0]         wdata_data,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [TW1-1:0]        done_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            err_code
);
    localparam logic [DATA_WIDTH:0] MEM_LIMIT = (DATA_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [AW:0]         RD_LIMIT  = (AW + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                  r_done_valid;
    logic [TW1-1:0]        r_done_data;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [1:0]            r_err;

    logic                  w_addr_ne;
    logic                  w_data_ne;
    logic [QW-1:0]         w_addr_head;
    logic [QW-1:0]         w_data_head;
    logic [DATA_WIDTH-1:0] w_addr_val;
    logic [DATA_WIDTH-1:0] w_data_val;
    logic [TW1-1:0]        w_addr_tag;
    logic [TW1-1:0]        w_data_tag;
    logic                  w_tag_match;
    logic                  w_both;
    logic                  w_slot_free;
    logic                  w_commit;
    logic                  w_mismatch;
    logic                  w_in_range;
    logic [AW-1:0]         w_mem_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    fabric_mem_store_port_queue #(.WIDTH(QW), .DEPTH(QUEUE_DEPTH)) u_addr_q (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (addr_valid),
        .i_data     (addr_data),
        .i_pop      (w_commit),
        .o_ready    (addr_ready),
        .o_nonempty (w_addr_ne),
        .o_head     (w_addr_head)
    );

    fabric_mem_store_port_queue #(.WIDTH(QW), .DEPTH(QUEUE_DEPTH)) u_data_q (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (wdata_valid),
        .i_data     (wdata_data),
        .i_pop      (w_commit),
        .o_ready    (wdata_ready),
        .o_nonempty (w_data_ne),
        .o_head     (w_data_head)
    );

    assign w_addr_val = w_addr_head[DATA_WIDTH-1:0];
    assign w_data_val = w_data_head[DATA_WIDTH-1:0];

    // Untagged builds compare two constant zeros, so the match is always true
    generate
        if (TAG_WIDTH > 0) begin : g_tag
            assign w_addr_tag = w_addr_head[QW-1:DATA_WIDTH];
            assign w_data_tag = w_data_head[QW-1:DATA_WIDTH];
        end else begin : g_notag
            assign w_addr_tag = '0;
            assign w_data_tag = '0;
        end
    endgenerate

    // A tag mismatch latches err_code[1], which also blocks every later commit
    always_comb begin
        w_both      = w_addr_ne && w_data_ne;
        w_tag_match = (w_addr_tag == w_data_tag);
        w_slot_free = !r_done_valid || done_ready;
        w_commit    = w_both && w_tag_match && w_slot_free && !r_err[1];
        w_mismatch  = w_both && !w_tag_match;
        w_in_range  = ({1'b0, w_addr_val} < MEM_LIMIT);
        w_mem_idx   = w_addr_val[AW-1:0];
        w_rd_word   = ({1'b0, rd_addr} < RD_LIMIT) ? r_mem[rd_addr] : '0;
    end

    // Array write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && w_in_range) begin
            r_mem[w_mem_idx] <= w_data_val;
        end
    end

    // Registered read port; same-edge commit is seen only by the next read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= w_rd_word;
        end
    end

    // Done token register and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_valid <= 1'b0;
            r_done_data  <= '0;
            r_err        <= 2'b00;
        end else begin
            if (w_commit) begin
                r_done_valid <= 1'b1;
                r_done_data  <= w_addr_tag;
            end else if (done_ready) begin
                r_done_valid <= 1'b0;
            end
            if (w_commit && !w_in_range) begin
                r_err[0] <= 1'b1;
            end
            if (w_mismatch) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign done_valid = r_done_valid;
    assign done_data  = r_done_data;
    assign rd_data    = r_rd_data;
    assign err_code   = r_err;
endmodule

// File: tb/tb_fabric_mem_store_port.sv
// Directed bench: an untagged instance driven from a vector table plus corner
// sequences, and a TAG_WIDTH=2 instance for tag ordering and mismatch stall.

module tb_fabric_mem_store_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Untagged instance signals
    logic        u_addr_valid, u_addr_ready, u_wdata_valid, u_wdata_ready;
    logic [31:0] u_addr_data, u_wdata_data, u_rd_data;
    logic        u_done_valid, u_done_ready, u_done_data, u_rd_en;
    logic [5:0]  u_rd_addr;
    logic [1:0]  u_err_code;

    // Tagged instance signals
    logic        t_addr_valid, t_addr_ready, t_wdata_valid, t_wdata_ready;
    logic [33:0] t_addr_data, t_wdata_data;
    logic [31:0] t_rd_data;
    logic        t_done_valid, t_done_ready, t_rd_en;
    logic [1:0]  t_done_data;
    logic [5:0]  t_rd_addr;
    logic [1:0]  t_err_code;

    fabric_mem_store_port u_dut (
        .clk(clk), .rst(rst),
        .addr_valid(u_addr_valid), .addr_ready(u_addr_ready), .addr_data(u_addr_data),
        .wdata_valid(u_wdata_valid), .wdata_ready(u_wdata_ready), .wdata_data(u_wdata_data),
        .done_valid(u_done_valid), .done_ready(u_done_ready), .done_data(u_done_data),
        .rd_en(u_rd_en), .rd_addr(u_rd_addr), .rd_data(u_rd_data), .err_code(u_err_code)
    );

    fabric_mem_store_port #(.TAG_WIDTH(2)) u_dut_t (
        .clk(clk), .rst(rst),
        .addr_valid(t_addr_valid), .addr_ready(t_addr_ready), .addr_data(t_addr_data),
        .wdata_valid(t_wdata_valid), .wdata_ready(t_wdata_ready), .wdata_data(t_wdata_data),
        .done_valid(t_done_valid), .done_ready(t_done_ready), .done_data(t_done_data),
        .rd_en(t_rd_en), .rd_addr(t_rd_addr), .rd_data(t_rd_data), .err_code(t_err_code)
    );

    int n_vec = 0;
    int n_err = 0;
    int u_tok_cnt = 0;
    logic [1:0] t_tok_q [$];

    // Token monitor: a token is consumed where valid and ready are both high
    always @(negedge clk) begin
        if (u_done_valid && u_done_ready) u_tok_cnt <= u_tok_cnt + 1;
        if (t_done_valid && t_done_ready) t_tok_q.push_back(t_done_data);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  rd_idx;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic store_u(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        u_addr_valid = 1'b1; u_addr_data = a;
        u_wdata_valid = 1'b1; u_wdata_data = d;
        @(posedge clk); #1;
        u_addr_valid = 1'b0; u_wdata_valid = 1'b0;
    endtask

    task automatic read_u(input string name, input logic [5:0] idx, input logic [31:0] exp);
        @(posedge clk); #1;
        u_rd_en = 1'b1; u_rd_addr = idx;
        @(posedge clk); #1;
        u_rd_en = 1'b0;
        @(negedge clk);
        check(name, 64'(u_rd_data), 64'(exp));
    endtask

    task automatic read_t(input string name, input logic [5:0] idx, input logic [31:0] exp);
        @(posedge clk); #1;
        t_rd_en = 1'b1; t_rd_addr = idx;
        @(posedge clk); #1;
        t_rd_en = 1'b0;
        @(negedge clk);
        check(name, 64'(t_rd_data), 64'(exp));
    endtask

    initial begin
        int base;
        vt[0] = '{32'd5,          32'hDEAD_BEEF, 6'd5,  32'hDEAD_BEEF, 2'b00};
        vt[1] = '{32'd0,          32'h0000_0001, 6'd0,  32'h0000_0001, 2'b00};
        vt[2] = '{32'd63,         32'hA5A5_5A5A, 6'd63, 32'hA5A5_5A5A, 2'b00};
        vt[3] = '{32'd5,          32'h1234_5678, 6'd5,  32'h1234_5678, 2'b00};
        vt[4] = '{32'd64,         32'hFFFF_FFFF, 6'd0,  32'h0000_0001, 2'b01};
        vt[5] = '{32'h8000_0005,  32'h0000_CAFE, 6'd5,  32'h1234_5678, 2'b01};

        u_addr_valid = 1'b0; u_addr_data = '0; u_wdata_valid = 1'b0; u_wdata_data = '0;
        u_done_ready = 1'b1; u_rd_en = 1'b0; u_rd_addr = '0;
        t_addr_valid = 1'b0; t_addr_data = '0; t_wdata_valid = 1'b0; t_wdata_data = '0;
        t_done_ready = 1'b1; t_rd_en = 1'b0; t_rd_addr = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_addr_ready", 64'(u_addr_ready), 64'd1);
        check("rst_wdata_ready", 64'(u_wdata_ready), 64'd1);
        check("rst_done_valid", 64'(u_done_valid), 64'd0);
        check("rst_done_data", 64'(u_done_data), 64'd0);
        check("rst_rd_data", 64'(u_rd_data), 64'd0);
        check("rst_err", 64'(u_err_code), 64'd0);
        check("rst_t_done_valid", 64'(t_done_valid), 64'd0);
        check("rst_t_err", 64'(t_err_code), 64'd0);

        // Tagged: tags 1 then 3 back to back, then a mismatched pair
        @(posedge clk); #1;
        t_addr_valid = 1'b1; t_addr_data = {2'd1, 32'd2};
        t_wdata_valid = 1'b1; t_wdata_data = {2'd1, 32'h11};
        @(posedge clk); #1;
        t_addr_data = {2'd3, 32'd4}; t_wdata_data = {2'd3, 32'h33};
        @(posedge clk); #1;
        t_addr_valid = 1'b0; t_wdata_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("t_tok_count", 64'(t_tok_q.size()), 64'd2);
        check("t_tok0", 64'((t_tok_q.size() > 0) ? t_tok_q[0] : 2'bxx), 64'd1);
        check("t_tok1", 64'((t_tok_q.size() > 1) ? t_tok_q[1] : 2'bxx), 64'd3);
        t_addr_valid = 1'b1; t_addr_data = {2'd2, 32'd8};
        t_wdata_valid = 1'b1; t_wdata_data = {2'd0, 32'h88};
        @(posedge clk); #1;
        t_addr_valid = 1'b0; t_wdata_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("t_mismatch_no_tok", 64'(t_tok_q.size()), 64'd2);
        check("t_mismatch_err", 64'(t_err_code), 64'd2);
        t_addr_valid = 1'b1; t_addr_data = {2'd1, 32'd9};
        t_wdata_valid = 1'b1; t_wdata_data = {2'd1, 32'h99};
        @(posedge clk); #1;
        t_addr_valid = 1'b0; t_wdata_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("t_stall_no_tok", 64'(t_tok_q.size()), 64'd2);
        check("t_stall_err", 64'(t_err_code), 64'd2);
        check("t_stall_ready", 64'(t_addr_ready), 64'd1);
        read_t("t_rd2", 6'd2, 32'h11);
        read_t("t_rd4", 6'd4, 32'h33);

        // Untagged vector table: latency, tag-less token, readback, sticky error
        for (int i = 0; i < 6; i++) begin
            store_u(vt[i].addr, vt[i].data);
            @(negedge clk);
            check($sformatf("v%0d_no_done_n1", i), 64'(u_done_valid), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_n2", i), 64'(u_done_valid), 64'd1);
            check($sformatf("v%0d_done_data", i), 64'(u_done_data), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_clear", i), 64'(u_done_valid), 64'd0);
            read_u($sformatf("v%0d_rd", i), vt[i].rd_idx, vt[i].exp_rd);
            check($sformatf("v%0d_err", i), 64'(u_err_code), 64'(vt[i].exp_err));
        end

        // Skewed arrival: addresses first, data four cycles later
        @(posedge clk); #1 base = u_tok_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            u_addr_valid = 1'b1; u_addr_data = 32'(i + 1);
        end
        @(posedge clk); #1 u_addr_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("skew_no_early_tok", 64'(u_tok_cnt - base), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            u_wdata_valid = 1'b1; u_wdata_data = 32'((i + 1) * 16);
        end
        @(posedge clk); #1 u_wdata_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("skew_tok_count", 64'(u_tok_cnt - base), 64'd3);
        read_u("skew_rd1", 6'd1, 32'h10);
        read_u("skew_rd2", 6'd2, 32'h20);
        read_u("skew_rd3", 6'd3, 32'h30);

        // Backpressure: five stores with done_ready low, then drain
        @(posedge clk); #1;
        u_done_ready = 1'b0; base = u_tok_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            u_addr_valid = 1'b1; u_addr_data = 32'(10 + i);
            u_wdata_valid = 1'b1; u_wdata_data = 32'(32'h100 + i);
        end
        @(posedge clk); #1;
        u_addr_data = 32'd15; u_wdata_data = 32'h105;
        @(negedge clk);
        check("bp_addr_ready_low", 64'(u_addr_ready), 64'd0);
        check("bp_wdata_ready_low", 64'(u_wdata_ready), 64'd0);
        check("bp_done_held", 64'(u_done_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_still_full", 64'(u_addr_ready), 64'd0);
        check("bp_one_commit", 64'(u_tok_cnt - base), 64'd0);
        @(posedge clk); #1;
        u_addr_valid = 1'b0; u_wdata_valid = 1'b0; u_done_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_drain%0d", i), 64'(u_done_valid), 64'd1);
        end
        @(negedge clk);
        check("bp_drain_end", 64'(u_done_valid), 64'd0);
        check("bp_tok_count", 64'(u_tok_cnt - base), 64'd5);
        check("bp_ready_back", 64'(u_wdata_ready), 64'd1);
        read_u("bp_rd10", 6'd10, 32'h100);
        read_u("bp_rd12", 6'd12, 32'h102);
        read_u("bp_rd14", 6'd14, 32'h104);

        // Reset mid-flight: one done pending and two entries queued
        @(posedge clk); #1 u_done_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            u_addr_valid = 1'b1; u_addr_data = 32'(20 + i);
            u_wdata_valid = 1'b1; u_wdata_data = 32'(32'h200 + i);
        end
        @(posedge clk); #1;
        u_addr_valid = 1'b0; u_wdata_valid = 1'b0;
        @(negedge clk);
        check("mr_done_pending", 64'(u_done_valid), 64'd1);
        check("mr_err_before", 64'(u_err_code), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mr_done_valid", 64'(u_done_valid), 64'd0);
        check("mr_addr_ready", 64'(u_addr_ready), 64'd1);
        check("mr_wdata_ready", 64'(u_wdata_ready), 64'd1);
        check("mr_err", 64'(u_err_code), 64'd0);
        check("mr_rd_data", 64'(u_rd_data), 64'd0);
        check("mr_t_err", 64'(t_err_code), 64'd0);
        u_done_ready = 1'b1;
        @(posedge clk); #1 base = u_tok_cnt;
        store_u(32'd7, 32'h77);
        @(negedge clk);
        check("mr_no_done_n1", 64'(u_done_valid), 64'd0);
        @(negedge clk);
        check("mr_done_n2", 64'(u_done_valid), 64'd1);
        repeat (3) @(posedge clk); #1;
        check("mr_tok_count", 64'(u_tok_cnt - base), 64'd1);
        read_u("mr_rd7", 6'd7, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fabric_mem_store_port.md
Name: fabric_mem_store_port

Overview:
- Memory-side responder for store traffic issued by store PEs.
- Accepts a store address stream and a store data stream on independent valid/ready channels, and buffers each in its own queue.
- Pairs queue heads, writes the data word into an internal memory array, then returns a done token carrying the store's tag.
- Provides a registered debug/read port so the array can be inspected and the fabric load path can be served.

Parameters:
DATA_WIDTH, 32, width of address value and data value
TAG_WIDTH, 0, tag width; 0 = untagged
MEM_DEPTH, 64, number of DATA_WIDTH-bit words in the array (>= 2)
QUEUE_DEPTH, 4, entries in each of the address queue and the data queue (>= 1)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
addr_valid  in  1  store address valid
addr_ready  out  1  address queue not full
addr_data  in  DATA_WIDTH+TAG_WIDTH  {tag, address}; address in the low DATA_WIDTH bits
wdata_valid  in  1  store data valid
wdata_ready  out  1  data queue not full
wdata_data  in  DATA_WIDTH+TAG_WIDTH  {tag, data}
done_valid  out  1  store-complete token valid
done_ready  in  1  consumer accepts done token
done_data  out  max(TAG_WIDTH,1)  tag of the completed store; 0 if untagged
rd_en  in  1  debug/load read request
rd_addr  in  clog2(MEM_DEPTH)  read index
rd_data  out  DATA_WIDTH  read result, valid one cycle after rd_en
err_code  out  2  sticky: bit0 = address out of range, bit1 = tag mismatch

Behaviour:
- Reset (rst=1 at posedge):
  - Both queues empty.
  - addr_ready=wdata_ready=1 the cycle after reset releases.
  - done_valid=0, done_data=0, rd_data=0, err_code=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all queued entries and any pending done token.
- Queues:
  - Circular FIFOs with pointers that wrap at QUEUE_DEPTH, plus an occupancy count.
  - ready = (count < QUEUE_DEPTH), derived from the registered count only; there is no same-cycle pass-through when full, even if a pop occurs that cycle.
  - Push on valid&&ready.
  - Simultaneous push and pop leaves count unchanged.
- Commit condition (evaluated each cycle):
  - Both queues non-empty.
  - Head tags equal (ignored when TAG_WIDTH=0).
  - Done slot free: done_valid=0, or done_valid && done_ready in the same cycle.
- On commit:
  - Both heads pop.
  - If address < MEM_DEPTH, mem[address] <= data. Otherwise the write is suppressed and err_code[0] is set.
  - The done register loads done_valid=1 and done_data=head tag, even for an out-of-range address.
- Tag mismatch with both heads present:
  - No commit; set err_code[1].
  - The block stalls permanently until reset (this is a mapping error).
- Done output:
  - Registered; done_valid holds until done_ready.
  - Back-to-back commits give one token per cycle when done_ready=1.
- Latency: address and data accepted at edge N -> heads visible in cycle N+1 -> commit at edge N+1 -> done_valid=1 in cycle N+2.
- Ordering: stores complete strictly in arrival order; the k-th address pairs with the k-th data word.
- Read port:
  - rd_data <= mem[rd_addr] at the edge where rd_en=1; otherwise rd_data holds its value.
  - Read and commit to the same index in the same cycle returns the old value (read-before-write).
- err_code bits are sticky until reset.

Test Plan:
1. Untagged single store: addr=5, data=0xDEADBEEF in the same cycle, done_ready=1 -> done_valid in cycle N+2; rd_en with rd_addr=5 -> rd_data=0xDEADBEEF.
2. Skewed arrival: 3 addresses (1,2,3), then data (0x10,0x20,0x30) arriving 4 cycles later -> mem[1..3]=0x10,0x20,0x30; exactly 3 done tokens, in order.
3. Backpressure: done_ready=0 while QUEUE_DEPTH+1 stores are offered -> exactly one commit; addr_ready and wdata_ready drop after 4 queued entries; releasing done_ready drains everything with one token per cycle.
4. Tagged mode (TAG_WIDTH=2): stores with tags 1, 3 -> done_data sequence 1, 3. Then address tag 2 with data tag 0 -> no done token, err_code=2'b10, stall persists.
5. Out of range: addr=64 with MEM_DEPTH=64 -> done token produced, memory unchanged, err_code[0]=1.
6. Reset mid-flight: 2 entries queued and done pending, assert rst for one cycle -> done_valid=0, both readys=1, err_code=0; subsequent store to addr 7 completes normally.
